// File: rtl/jtag_host_pkg.sv
// Shared types, TMS sequence tables and the TAP state transition function for the JTAG host.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IDLE    = 2'd1,
        OP_IR_SCAN = 2'd2,
        OP_DR_SCAN = 2'd3
    } jtag_host_op_e;

    typedef enum logic [3:0] {
        TestLogicReset = 4'd0,
        RunTestIdle    = 4'd1,
        SelectDrScan   = 4'd2,
        CaptureDr      = 4'd3,
        ShiftDr        = 4'd4,
        Exit1Dr        = 4'd5,
        PauseDr        = 4'd6,
        Exit2Dr        = 4'd7,
        UpdateDr       = 4'd8,
        SelectIrScan   = 4'd9,
        CaptureIr      = 4'd10,
        ShiftIr        = 4'd11,
        Exit1Ir        = 4'd12,
        PauseIr        = 4'd13,
        Exit2Ir        = 4'd14,
        UpdateIr       = 4'd15
    } tap_state_e;

    // TMS patterns, LSB is the first TCK cycle
    localparam logic [3:0] IrHdr    = 4'b0011;
    localparam logic [2:0] DrHdr    = 3'b001;
    localparam logic [1:0] Trl      = 2'b01;
    localparam logic [5:0] ResetSeq = 6'b011111;

    localparam int unsigned IrHdrLen    = 4;
    localparam int unsigned DrHdrLen    = 3;
    localparam int unsigned TrlLen      = 2;
    localparam int unsigned ResetSeqLen = 6;

    localparam int unsigned SeqIdxW = 3;
    localparam logic [SeqIdxW-1:0] TrlLast = SeqIdxW'(TrlLen - 1);

    // TMS for header position idx of a table-driven op
    function automatic logic hdr_tms(jtag_host_op_e op, logic [SeqIdxW-1:0] idx);
        logic [7:0] seq;
        seq = 8'h00;
        case (op)
            OP_RESET:   seq = {2'b00, ResetSeq};
            OP_IR_SCAN: seq = {4'b0000, IrHdr};
            OP_DR_SCAN: seq = {5'b00000, DrHdr};
            default:    seq = 8'h00;
        endcase
        return seq[idx];
    endfunction

    // Index of the final header cycle of a table-driven op
    function automatic logic [SeqIdxW-1:0] hdr_last(jtag_host_op_e op);
        case (op)
            OP_RESET:   return SeqIdxW'(ResetSeqLen - 1);
            OP_IR_SCAN: return SeqIdxW'(IrHdrLen - 1);
            OP_DR_SCAN: return SeqIdxW'(DrHdrLen - 1);
            default:    return '0;
        endcase
    endfunction

    function automatic logic trl_tms(logic [SeqIdxW-1:0] idx);
        logic [7:0] seq;
        seq = {6'b000000, Trl};
        return seq[idx];
    endfunction

    function automatic tap_state_e jtag_next_state(tap_state_e s, logic tms);
        case (s)
            TestLogicReset: return tms ? TestLogicReset : RunTestIdle;
            RunTestIdle:    return tms ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   return tms ? SelectIrScan   : CaptureDr;
            CaptureDr:      return tms ? Exit1Dr        : ShiftDr;
            ShiftDr:        return tms ? Exit1Dr        : ShiftDr;
            Exit1Dr:        return tms ? UpdateDr       : PauseDr;
            PauseDr:        return tms ? Exit2Dr        : PauseDr;
            Exit2Dr:        return tms ? UpdateDr       : ShiftDr;
            UpdateDr:       return tms ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   return tms ? TestLogicReset : CaptureIr;
            CaptureIr:      return tms ? Exit1Ir        : ShiftIr;
            ShiftIr:        return tms ? Exit1Ir        : ShiftIr;
            Exit1Ir:        return tms ? UpdateIr       : PauseIr;
            PauseIr:        return tms ? Exit2Ir        : PauseIr;
            Exit2Ir:        return tms ? UpdateIr       : ShiftIr;
            UpdateIr:       return tms ? SelectDrScan   : RunTestIdle;
            default:        return TestLogicReset;
        endcase
    endfunction

endpackage

// File: rtl/jtag_host_clkgen.sv
// TCK generator: ClkDiv clk cycles per half-period, low phase first, idles low when disabled.
// rise_stb_o/fall_stb_o are high in the clk cycle before the edge that moves tck_o.
module jtag_host_clkgen #(
    parameter int unsigned ClkDiv = 2
) (
    input  logic clk_i,
    input  logic trst_ni,
    input  logic en_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tck_q, tck_d;
    logic            phase_end;

    assign phase_end  = en_i && (cnt_q == CntMax);
    assign rise_stb_o = phase_end && !tck_q;
    assign fall_stb_o = phase_end && tck_q;
    assign tck_o      = tck_q;

    // Half-period counter and TCK toggle; disabled resets to start of a low phase
    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (phase_end) begin
            cnt_d = '0;
            tck_d = !tck_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter and TCK registers
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_host_master.sv
// JTAG host: executes reset/idle/IR-scan/DR-scan commands and returns captured TDO bits.
// Optional TAP state mirror output tap_state_o when JTAG_HOST_STATE_MON_EN is defined.
module jtag_host_master
    import jtag_host_pkg::*;
#(
    parameter int unsigned ClkDiv = 2,
    parameter int unsigned MaxLen = 64,
    parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              trst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  jtag_host_op_e     cmd_op_i,
    input  logic [LenW-1:0]   cmd_len_i,
    input  logic [MaxLen-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i,
`ifdef JTAG_HOST_STATE_MON_EN
    output tap_state_e        tap_state_o,
`endif
    output logic              jtag_trst_no
);

    localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    typedef enum logic [2:0] {StIdle, StHdr, StShift, StTrl, StRsp} state_e;

    state_e               state_q, state_d;
    jtag_host_op_e        op_q, op_d;
    logic [LenW-1:0]      len_q, len_d;
    logic [LenW-1:0]      rem_q, rem_d;
    logic [SeqIdxW-1:0]   seq_q, seq_d;
    logic [MaxLen-1:0]    data_q, data_d;
    logic [MaxLen-1:0]    cap_q, cap_d;
    logic                 tms_q, tms_d;
    logic                 tdi_q, tdi_d;
    logic                 ready_q;
    logic                 clk_en, rise_stb, fall_stb;
    logic [IdxW-1:0]      pos;

    function automatic logic [LenW-1:0] clamp_len(logic [LenW-1:0] l);
        if (l == '0) return LenW'(1);
        if (l > LenW'(MaxLen)) return LenW'(MaxLen);
        return l;
    endfunction

    assign clk_en = (state_q == StHdr) || (state_q == StShift) || (state_q == StTrl);
    // Capture slot of the current shift bit
    assign pos    = IdxW'(len_q - rem_q);

    jtag_host_clkgen #(
        .ClkDiv (ClkDiv)
    ) u_clkgen (
        .clk_i      (clk_i),
        .trst_ni    (trst_ni),
        .en_i       (clk_en),
        .tck_o      (tck_o),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    // Next-state: command accept, sequence stepping on TCK fall, TDO capture on TCK rise
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        data_d  = data_q;
        cap_d   = cap_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && ready_q) begin
                    op_d   = cmd_op_i;
                    data_d = cmd_data_i;
                    cap_d  = '0;
                    seq_d  = '0;
                    tdi_d  = 1'b0;
                    if (cmd_op_i == OP_IDLE) begin
                        len_d   = cmd_len_i;
                        rem_d   = cmd_len_i;
                        tms_d   = 1'b0;
                        state_d = (cmd_len_i == '0) ? StRsp : StHdr;
                    end else begin
                        len_d   = clamp_len(cmd_len_i);
                        rem_d   = clamp_len(cmd_len_i);
                        tms_d   = hdr_tms(cmd_op_i, '0);
                        state_d = StHdr;
                    end
                end
            end
            StHdr: begin
                if (fall_stb) begin
                    seq_d = seq_q + SeqIdxW'(1);
                    if (op_q == OP_IDLE) begin
                        rem_d = rem_q - LenW'(1);
                        if (rem_q == LenW'(1)) state_d = StRsp;
                    end else if (seq_q == hdr_last(op_q)) begin
                        if (op_q == OP_RESET) begin
                            tms_d   = 1'b0;
                            state_d = StRsp;
                        end else begin
                            tms_d   = (rem_q == LenW'(1));
                            tdi_d   = data_q[0];
                            data_d  = data_q >> 1;
                            state_d = StShift;
                        end
                    end else begin
                        tms_d = hdr_tms(op_q, seq_q + SeqIdxW'(1));
                    end
                end
            end
            StShift: begin
                if (rise_stb) cap_d[pos] = tdo_i;
                if (fall_stb) begin
                    rem_d = rem_q - LenW'(1);
                    if (rem_q == LenW'(1)) begin
                        seq_d   = '0;
                        tms_d   = trl_tms('0);
                        tdi_d   = 1'b0;
                        state_d = StTrl;
                    end else begin
                        tms_d  = (rem_q == LenW'(2));
                        tdi_d  = data_q[0];
                        data_d = data_q >> 1;
                    end
                end
            end
            StTrl: begin
                if (fall_stb) begin
                    if (seq_q == TrlLast) begin
                        tms_d   = 1'b0;
                        state_d = StRsp;
                    end else begin
                        seq_d = seq_q + SeqIdxW'(1);
                        tms_d = trl_tms(seq_q + SeqIdxW'(1));
                    end
                end
            end
            StRsp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; ready is registered so it reads 0 while in reset
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= StIdle;
            op_q    <= OP_RESET;
            len_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= (state_d == StIdle);
        end
    end

    assign cmd_ready_o  = ready_q;
    assign rsp_valid_o  = (state_q == StRsp);
    assign rsp_data_o   = cap_q;
    assign tms_o        = tms_q;
    assign tdi_o        = tdi_q;
    assign jtag_trst_no = trst_ni;

`ifdef JTAG_HOST_STATE_MON_EN
    tap_state_e tap_state_q;

    // Mirror of the target TAP, advanced with the TMS value seen at each TCK rise
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tap_state_q <= RunTestIdle;
        end else if (rise_stb) begin
            tap_state_q <= jtag_next_state(tap_state_q, tms_q);
        end
    end

    assign tap_state_o = tap_state_q;

    parked_in_rti: assert property (@(posedge clk_i) disable iff (!trst_ni)
        cmd_ready_o |-> (tap_state_q == RunTestIdle));
`endif

endmodule

// File: tb/tb_jtag_host_master.sv
// Directed bench for jtag_host_master against a behavioural 5-bit-IR TAP (IDCODE + BYPASS).
module tb_jtag_host_master;
    import jtag_host_pkg::*;

    localparam int unsigned MaxLen      = 64;
    localparam int unsigned LenW        = 7;
    localparam logic [31:0] IdcodeValue = 32'h0000_0001;
    localparam logic [4:0]  IrIdcode    = 5'h01;
    localparam logic [4:0]  IrCapture   = 5'b00101;

    localparam logic [3:0] Tlr = 4'd0,  Rti = 4'd1,  SelDr = 4'd2,  CapDr = 4'd3;
    localparam logic [3:0] ShDr = 4'd4, Ex1Dr = 4'd5, PsDr = 4'd6,  Ex2Dr = 4'd7;
    localparam logic [3:0] UpdDr = 4'd8, SelIr = 4'd9, CapIr = 4'd10, ShIr = 4'd11;
    localparam logic [3:0] Ex1Ir = 4'd12, PsIr = 4'd13, Ex2Ir = 4'd14, UpdIr = 4'd15;

    logic              clk = 1'b0;
    logic              trst_n = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    jtag_host_op_e     cmd_op = OP_RESET;
    logic [LenW-1:0]   cmd_len = '0;
    logic [MaxLen-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [MaxLen-1:0] rsp_data;
    logic              tck, tms, tdi, tdo;
    logic              jtag_trst_n;
`ifdef JTAG_HOST_STATE_MON_EN
    tap_state_e        tap_state;
`endif

    int unsigned n_asserts = 0;
    int unsigned n_fails = 0;

    always #5 clk = ~clk;

    jtag_host_master #(
        .ClkDiv (2),
        .MaxLen (MaxLen)
    ) dut (
        .clk_i        (clk),
        .trst_ni      (trst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .tck_o        (tck),
        .tms_o        (tms),
        .tdi_o        (tdi),
        .tdo_i        (tdo),
`ifdef JTAG_HOST_STATE_MON_EN
        .tap_state_o  (tap_state),
`endif
        .jtag_trst_no (jtag_trst_n)
    );

    // ---------------- behavioural TAP ----------------
    logic [3:0]  tap_st;
    logic [4:0]  ir, ir_sr;
    logic [31:0] id_sr;
    logic        bp;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            Tlr:     return m ? Tlr   : Rti;
            Rti:     return m ? SelDr : Rti;
            SelDr:   return m ? SelIr : CapDr;
            CapDr:   return m ? Ex1Dr : ShDr;
            ShDr:    return m ? Ex1Dr : ShDr;
            Ex1Dr:   return m ? UpdDr : PsDr;
            PsDr:    return m ? Ex2Dr : PsDr;
            Ex2Dr:   return m ? UpdDr : ShDr;
            UpdDr:   return m ? SelDr : Rti;
            SelIr:   return m ? Tlr   : CapIr;
            CapIr:   return m ? Ex1Ir : ShIr;
            ShIr:    return m ? Ex1Ir : ShIr;
            Ex1Ir:   return m ? UpdIr : PsIr;
            PsIr:    return m ? Ex2Ir : PsIr;
            Ex2Ir:   return m ? UpdIr : ShIr;
            default: return m ? SelDr : Rti;
        endcase
    endfunction

    always @(posedge tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            tap_st <= Rti;
            ir     <= IrIdcode;
        end else begin
            case (tap_st)
                CapDr: if (ir == IrIdcode) id_sr <= IdcodeValue; else bp <= 1'b0;
                ShDr:  if (ir == IrIdcode) id_sr <= {tdi, id_sr[31:1]}; else bp <= tdi;
                CapIr: ir_sr <= IrCapture;
                ShIr:  ir_sr <= {tdi, ir_sr[4:1]};
                UpdIr: ir <= ir_sr;
                Tlr:   ir <= IrIdcode;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) tdo <= 1'b0;
        else if (tap_st == ShDr) tdo <= (ir == IrIdcode) ? id_sr[0] : bp;
        else if (tap_st == ShIr) tdo <= ir_sr[0];
        else tdo <= 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input jtag_host_op_e op, input logic [LenW-1:0] len,
                            input logic [63:0] data);
        int unsigned waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_op    = OP_IR_SCAN;
            cmd_len   = 7'h7f;
            cmd_data  = {$urandom, $urandom};
        end
    endtask

    task automatic get_rsp(output logic [63:0] d);
        int unsigned waited = 0;
        @(negedge clk);
        while (!rsp_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) begin
            check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
            d = '1;
        end else begin
            d = rsp_data;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic scan(input string tag, input jtag_host_op_e op, input logic [LenW-1:0] len,
                        input logic [63:0] data, input logic [63:0] exp);
        logic [63:0] d;
        send_cmd(op, len, data);
        get_rsp(d);
        check(tag, d, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [63:0] d, held;
    int unsigned cyc, rises, last_fall, bad;
    logic        prev;
    logic [5:0]  tms_seq;

    initial begin
        #2 trst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tck", 64'(tck), 64'd0);
        check("reset_tms", 64'(tms), 64'd0);
        check("reset_tdi", 64'(tdi), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_jtag_trst", 64'(jtag_trst_n), 64'd0);
        @(negedge clk);
        trst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(cmd_ready), 64'd1);
        check("jtag_trst_released", 64'(jtag_trst_n), 64'd1);

        // IDCODE read
        scan("op_reset_rsp", OP_RESET, 7'd0, 64'hFFFF, 64'd0);
        scan("ir_idcode", OP_IR_SCAN, 7'd5, 64'h01, 64'h05);
        scan("dr_idcode", OP_DR_SCAN, 7'd32, 64'd0, 64'h0000_0001);

        // BYPASS
        scan("ir_bypass", OP_IR_SCAN, 7'd5, 64'h1f, 64'h05);
        scan("dr_bypass8", OP_DR_SCAN, 7'd8, 64'hA5, 64'h4A);

        // Timing of a one-bit DR scan
        send_cmd(OP_DR_SCAN, 7'd1, 64'h1);
        cyc = 0; rises = 0; last_fall = 0; prev = 1'b0; bad = 0; tms_seq = '0;
        while (!rsp_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tck && !prev) begin
                if (rises < 6) tms_seq[rises] = tms;
                rises++;
            end
            if (!tck && prev) last_fall = cyc;
            if (cmd_ready) bad++;
            prev = tck;
        end
        check("len1_tck_pulses", 64'(rises), 64'd6);
        check("len1_last_fall_clk", 64'(last_fall), 64'd24);
        check("len1_tms_seq", 64'(tms_seq), 64'b011001);
        check("len1_ready_low", 64'(bad), 64'd0);
        get_rsp(d);
        check("len1_rsp_no_tdi", d, 64'd0);

        // Response backpressure
        send_cmd(OP_DR_SCAN, 7'd8, 64'h3C);
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        held = rsp_data;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || cmd_ready) bad++;
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        check("bp_data", held, 64'h78);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_ready_after_release", 64'(cmd_ready), 64'd1);
        check("bp_valid_dropped", 64'(rsp_valid), 64'd0);

        // Reset in the 20th bit of a 64-bit DR scan (3 header rises + 20 shift rises)
        send_cmd(OP_DR_SCAN, 7'd64, '1);
        cyc = 0; rises = 0; prev = 1'b0;
        while (rises < 23 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tck && !prev) rises++;
            prev = tck;
        end
        check("midscan_reached_bit20", 64'(rises), 64'd23);
        @(negedge clk);
        trst_n = 1'b0;
        #1;
        check("midscan_tck", 64'(tck), 64'd0);
        check("midscan_tms", 64'(tms), 64'd0);
        check("midscan_tdi", 64'(tdi), 64'd0);
        check("midscan_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midscan_jtag_trst", 64'(jtag_trst_n), 64'd0);
        repeat (3) @(negedge clk);
        trst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || tck) bad++;
        end
        check("midscan_no_response", 64'(bad), 64'd0);
        scan("post_reset_ir_idcode", OP_IR_SCAN, 7'd5, 64'h01, 64'h05);
        scan("post_reset_dr_idcode", OP_DR_SCAN, 7'd32, 64'd0, 64'h0000_0001);

        // Length clamping (IDCODE selected)
        scan("dr_len0_clamp", OP_DR_SCAN, 7'd0, 64'd0, 64'h1);
        scan("dr_len100_clamp", OP_DR_SCAN, 7'd100, 64'hDEADBEEF_12345678,
             64'h12345678_00000001);

        // OP_IDLE with zero length: response one clk after acceptance, no TCK
        send_cmd(OP_IDLE, 7'd0, '1);
        check("idle0_rsp_next_clk", 64'(rsp_valid), 64'd1);
        check("idle0_no_tck", 64'(tck), 64'd0);
        get_rsp(d);
        check("idle0_rsp_data", d, 64'd0);

        // OP_IDLE with three TCK cycles
        send_cmd(OP_IDLE, 7'd3, '1);
        cyc = 0; rises = 0; prev = 1'b0; bad = 0;
        while (!rsp_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tck && !prev) rises++;
            if (tck && tms) bad++;
            prev = tck;
        end
        check("idle3_tck_pulses", 64'(rises), 64'd3);
        check("idle3_tms_low", 64'(bad), 64'd0);
        get_rsp(d);
        check("idle3_rsp_data", d, 64'd0);

        // Full-length scan through BYPASS
        scan("ir_bypass2", OP_IR_SCAN, 7'd5, 64'h1f, 64'h05);
        scan("dr_bypass64", OP_DR_SCAN, 7'd64, '1, 64'hFFFF_FFFF_FFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
